// File: rtl/fxp_pkg.sv
// Shared constants and helpers for the fixed-point multiply-accumulate block.
package fxp_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;
  localparam int SAT_WRAP      = 0;
  localparam int SAT_CLAMP     = 1;

  // Ceiling log2; clog2(1) = 0 so a single-product group needs no guard bits.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fxp_format.sv
// Combinational output formatter: fraction alignment, optional rounding,
// range check and clamp/wrap of the accumulated sum.
module fxp_format
  import fxp_pkg::*;
#(
  parameter int IN_W     = 17,
  parameter int IN_F     = 4,
  parameter int OUT_I    = 5,
  parameter int OUT_F    = 3,
  parameter int ROUND    = ROUND_TRUNC,
  parameter int SATURATE = SAT_CLAMP
) (
  input  logic [IN_W-1:0]        din,
  output logic [OUT_I+OUT_F-1:0] dout,
  output logic                   ovf,
  output logic                   unf
);

  localparam int OW  = OUT_I + OUT_F;
  localparam int RSH = (IN_F > OUT_F) ? IN_F - OUT_F : 0;
  localparam int LSH = (OUT_F > IN_F) ? OUT_F - IN_F : 0;
  // One spare bit absorbs a rounding carry; never narrower than OW+1 so limits fit.
  localparam int W0  = IN_W + LSH + 1;
  localparam int W   = (W0 > OW + 1) ? W0 : OW + 1;

  localparam logic signed [W-1:0] MAX_V = {{(W - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V = {{(W - OW + 1){1'b1}}, {(OW - 1){1'b0}}};

  logic signed [W-1:0] ext;
  logic signed [W-1:0] biased;
  logic signed [W-1:0] aligned;

  assign ext = W'($signed(din));

  generate
    if (ROUND == ROUND_HALF_UP && RSH > 0) begin : g_round
      localparam logic signed [W-1:0] HALF = W'(1) << (RSH - 1);
      assign biased = ext + HALF;
    end else begin : g_trunc
      assign biased = ext;
    end
  endgenerate

  assign aligned = (biased >>> RSH) <<< LSH;
  assign ovf     = aligned > MAX_V;
  assign unf     = aligned < MIN_V;

  always_comb begin
    dout = aligned[OW-1:0];
    if (SATURATE == SAT_CLAMP) begin
      if (ovf)      dout = {1'b0, {(OW - 1){1'b1}}};
      else if (unf) dout = {1'b1, {(OW - 1){1'b0}}};
    end
  end

endmodule

// File: rtl/fixed_point_mac.sv
// Three-stage fixed-point multiply-accumulate: operand register, product
// register, accumulate-and-format into a registered output.
module fixed_point_mac
  import fxp_pkg::*;
#(
  parameter int I1       = 3,
  parameter int F1       = 2,
  parameter int I2       = 4,
  parameter int F2       = 2,
  parameter int OUT_I    = 5,
  parameter int OUT_F    = 3,
  parameter int ACC_LEN  = 1,
  parameter int ROUND    = ROUND_TRUNC,
  parameter int SATURATE = SAT_CLAMP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [I1+F1-1:0]       a,
  input  logic [I2+F2-1:0]       b,
  input  logic                   clear,
  output logic                   out_valid,
  output logic [OUT_I+OUT_F-1:0] out,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW    = I1 + F1;
  localparam int BW    = I2 + F2;
  localparam int PW    = AW + BW;
  localparam int PF    = F1 + F2;
  localparam int G     = clog2(ACC_LEN);
  localparam int ACC_W = PW + G;
  localparam int CW    = (G > 0) ? G : 1;
  localparam int OW    = OUT_I + OUT_F;

  logic [AW-1:0]    a_reg;
  logic [BW-1:0]    b_reg;
  logic             s1_valid_reg;
  logic [PW-1:0]    prod_reg;
  logic             s2_valid_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [CW-1:0]    cnt_reg;
  logic [OW-1:0]    out_reg;
  logic             out_valid_reg;
  logic             overflow_reg;
  logic             underflow_reg;

  logic signed [PW-1:0]    a_ext;
  logic signed [PW-1:0]    b_ext;
  logic [PW-1:0]           prod_next;
  logic signed [ACC_W-1:0] acc_sum;
  logic                    last_in_group;
  logic                    accept;
  logic                    emit;
  logic [OW-1:0]           fmt_out;
  logic                    fmt_ovf;
  logic                    fmt_unf;

  assign a_ext     = PW'($signed(a_reg));
  assign b_ext     = PW'($signed(b_reg));
  assign prod_next = a_ext * b_ext;

  assign acc_sum       = $signed(acc_reg) + ACC_W'($signed(prod_reg));
  assign last_in_group = (cnt_reg == CW'(ACC_LEN - 1));
  // clear outranks a product arriving in the same cycle, including a group's last one
  assign accept        = s2_valid_reg & ~clear;
  assign emit          = accept & last_in_group;

  fxp_format #(
    .IN_W     (ACC_W),
    .IN_F     (PF),
    .OUT_I    (OUT_I),
    .OUT_F    (OUT_F),
    .ROUND    (ROUND),
    .SATURATE (SATURATE)
  ) u_format (
    .din  (acc_sum),
    .dout (fmt_out),
    .ovf  (fmt_ovf),
    .unf  (fmt_unf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg         <= '0;
      b_reg         <= '0;
      s1_valid_reg  <= 1'b0;
      prod_reg      <= '0;
      s2_valid_reg  <= 1'b0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (in_valid) begin
        a_reg <= a;
        b_reg <= b;
      end
      s1_valid_reg  <= in_valid & ~clear;
      prod_reg      <= prod_next;
      s2_valid_reg  <= s1_valid_reg & ~clear;
      out_valid_reg <= emit;
      overflow_reg  <= emit & fmt_ovf;
      underflow_reg <= emit & fmt_unf;
      if (emit) out_reg <= fmt_out;

      if (clear) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else if (s2_valid_reg) begin
        if (last_in_group) begin
          acc_reg <= '0;
          cnt_reg <= '0;
        end else begin
          acc_reg <= acc_sum;
          cnt_reg <= cnt_reg + CW'(1);
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out       = out_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_fixed_point_mac.sv
// Directed bench for fixed_point_mac: several parameterisations share one
// clock, reset and operand bus, each with its own in_valid.
module tb_fixed_point_mac;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic [4:0] a;
  logic [5:0] b;
  logic       iv_def, iv_wrap, iv_acc, iv_rnd, iv_trn;

  logic       ov_def, ov_wrap, ov_acc, ov_rnd, ov_trn;
  logic [7:0] out_def, out_wrap, out_acc;
  logic [5:0] out_rnd, out_trn;
  logic       of_def, of_wrap, of_acc, of_rnd, of_trn;
  logic       uf_def, uf_wrap, uf_acc, uf_rnd, uf_trn;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  fixed_point_mac u_def (
    .clk(clk), .rst(rst), .in_valid(iv_def), .a(a), .b(b), .clear(clear),
    .out_valid(ov_def), .out(out_def), .overflow(of_def), .underflow(uf_def));

  fixed_point_mac #(.SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(iv_wrap), .a(a), .b(b), .clear(clear),
    .out_valid(ov_wrap), .out(out_wrap), .overflow(of_wrap), .underflow(uf_wrap));

  fixed_point_mac #(.ACC_LEN(4)) u_acc (
    .clk(clk), .rst(rst), .in_valid(iv_acc), .a(a), .b(b), .clear(clear),
    .out_valid(ov_acc), .out(out_acc), .overflow(of_acc), .underflow(uf_acc));

  fixed_point_mac #(.OUT_F(1), .ROUND(1)) u_rnd (
    .clk(clk), .rst(rst), .in_valid(iv_rnd), .a(a), .b(b), .clear(clear),
    .out_valid(ov_rnd), .out(out_rnd), .overflow(of_rnd), .underflow(uf_rnd));

  fixed_point_mac #(.OUT_F(1), .ROUND(0)) u_trn (
    .clk(clk), .rst(rst), .in_valid(iv_trn), .a(a), .b(b), .clear(clear),
    .out_valid(ov_trn), .out(out_trn), .overflow(of_trn), .underflow(uf_trn));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("miscompare in %s", tag);
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; a = '0; b = '0;
    iv_def = 0; iv_wrap = 0; iv_acc = 0; iv_rnd = 0; iv_trn = 0;
    tick(); tick();
    chk("rst_valid",  {31'd0, ov_def}, 32'd0);
    chk("rst_out",    {24'd0, out_def}, 32'd0);
    chk("rst_ovf",    {31'd0, of_def}, 32'd0);
    chk("rst_unf",    {31'd0, uf_def}, 32'd0);
    chk("rst_accval", {31'd0, ov_acc}, 32'd0);
    rst = 1'b0;
    tick();

    // 1.5 x 1.5 = 2.25 -> 0x12, three-cycle latency
    a = 5'b00110; b = 6'b000110; iv_def = 1;
    tick(); iv_def = 0;
    $display("mul 1.5x1.5 applied");
    chk("mul_lat1", {31'd0, ov_def}, 32'd0);
    tick();
    chk("mul_lat2", {31'd0, ov_def}, 32'd0);
    tick();
    chk("mul_valid", {31'd0, ov_def}, 32'd1);
    chk("mul_out",   {24'd0, out_def}, 32'h12);
    chk("mul_ovf",   {31'd0, of_def}, 32'd0);
    chk("mul_unf",   {31'd0, uf_def}, 32'd0);
    tick();
    chk("mul_pulse", {31'd0, ov_def}, 32'd0);
    chk("mul_hold",  {24'd0, out_def}, 32'h12);

    // 3.75 x 7.75 overflows: clamp and wrap
    a = 5'b01111; b = 6'b011111; iv_def = 1; iv_wrap = 1;
    tick(); iv_def = 0; iv_wrap = 0;
    $display("ovf 3.75x7.75 applied");
    tick(); tick();
    chk("ovf_valid",    {31'd0, ov_def}, 32'd1);
    chk("ovf_out",      {24'd0, out_def}, 32'h7F);
    chk("ovf_flag",     {31'd0, of_def}, 32'd1);
    chk("ovf_unf",      {31'd0, uf_def}, 32'd0);
    chk("wrap_valid",   {31'd0, ov_wrap}, 32'd1);
    chk("wrap_out",     {24'd0, out_wrap}, 32'hE8);
    chk("wrap_flag",    {31'd0, of_wrap}, 32'd1);
    tick();
    chk("ovf_idle_flag", {31'd0, of_def}, 32'd0);
    chk("ovf_hold",      {24'd0, out_def}, 32'h7F);

    // -4 x 7 underflows
    a = 5'b10000; b = 6'b011100; iv_def = 1;
    tick(); iv_def = 0;
    $display("unf -4x7 applied");
    tick(); tick();
    chk("unf_valid", {31'd0, ov_def}, 32'd1);
    chk("unf_out",   {24'd0, out_def}, 32'h80);
    chk("unf_flag",  {31'd0, uf_def}, 32'd1);
    chk("unf_ovf",   {31'd0, of_def}, 32'd0);
    tick();

    // 0.75 x 1.25 = 0.9375 at one fraction bit: round -> 1.0, truncate -> 0.5
    a = 5'b00011; b = 6'b000101; iv_rnd = 1; iv_trn = 1;
    tick(); iv_rnd = 0; iv_trn = 0;
    $display("round 0.75x1.25 applied");
    tick(); tick();
    chk("rnd_valid", {31'd0, ov_rnd}, 32'd1);
    chk("rnd_out",   {26'd0, out_rnd}, 32'h02);
    chk("trn_valid", {31'd0, ov_trn}, 32'd1);
    chk("trn_out",   {26'd0, out_trn}, 32'h01);
    tick();

    // ACC_LEN=4: four 1.0 x 1.0 products -> 4.0
    a = 5'b00100; b = 6'b000100; iv_acc = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("acc_nopulse", {31'd0, ov_acc}, 32'd0);
    end
    iv_acc = 0;
    $display("acc group of four applied");
    tick();
    chk("acc_lat", {31'd0, ov_acc}, 32'd0);
    tick();
    chk("acc_valid", {31'd0, ov_acc}, 32'd1);
    chk("acc_out",   {24'd0, out_acc}, 32'h20);
    tick();
    chk("acc_pulse", {31'd0, ov_acc}, 32'd0);

    // two pairs, clear (with an ignored in_valid), then a full group
    iv_acc = 1;
    tick(); tick();
    clear = 1;
    tick();
    clear = 0;
    chk("clr_nopulse", {31'd0, ov_acc}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("clr_group", {31'd0, ov_acc}, 32'd0);
    end
    iv_acc = 0;
    $display("clear then group applied");
    tick();
    chk("clr_lat", {31'd0, ov_acc}, 32'd0);
    tick();
    chk("clr_valid", {31'd0, ov_acc}, 32'd1);
    chk("clr_out",   {24'd0, out_acc}, 32'h20);
    tick();
    chk("clr_pulse", {31'd0, ov_acc}, 32'd0);

    // clear coinciding with the group's last product suppresses the result
    iv_acc = 1;
    for (int i = 0; i < 4; i++) tick();
    iv_acc = 0;
    tick();
    clear = 1;
    tick();
    clear = 0;
    $display("clear at final product applied");
    for (int i = 0; i < 3; i++) begin
      chk("clr_final_none", {31'd0, ov_acc}, 32'd0);
      tick();
    end

    // reset mid-group discards in-flight data
    iv_acc = 1;
    tick(); tick();
    iv_acc = 0; rst = 1;
    tick();
    rst = 0;
    $display("reset mid-group applied");
    chk("rst_mid_out",   {24'd0, out_acc}, 32'h00);
    chk("rst_mid_valid", {31'd0, ov_acc}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_mid_none", {31'd0, ov_acc}, 32'd0);
    end
    iv_acc = 1;
    for (int i = 0; i < 4; i++) tick();
    iv_acc = 0;
    tick();
    chk("rst_grp_lat", {31'd0, ov_acc}, 32'd0);
    tick();
    chk("rst_grp_valid", {31'd0, ov_acc}, 32'd1);
    chk("rst_grp_out",   {24'd0, out_acc}, 32'h20);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
